// File: rtl/cache_access_arbiter.sv
// Arbitrates CPU requests and interconnect snoops for a single cache
// controller port. Snoops are favoured, but a CPU request that has been
// passed over MAX_SNP_BURST times in a row wins the next grant. Each
// operation is issued for one cycle and then tracked until cache_complete
// or until TIMEOUT_CYCLES cycles pass without completion.
//
// Handshake: a requester raises *_valid with its op and holds both stable
// until it sees the matching *_accept pulse. The accept is asserted
// combinationally in the IDLE cycle where the grant is made and lasts one
// cycle. A request is eligible only when its op is arbitrable: CPU ops
// 00/01, or any snoop op except 11. No accept is given while busy is high.
module cache_access_arbiter #(
    parameter int MAX_SNP_BURST  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_valid,
    input  logic [1:0] cpu_op,
    output logic       cpu_accept,
    input  logic       snp_valid,
    input  logic [1:0] snp_op,
    output logic       snp_accept,
    output logic [1:0] cache_request,
    input  logic       cache_ready,
    input  logic       cache_complete,
    output logic       cpu_done,
    output logic       snp_done,
    output logic       owner,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_SNP_BURST);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] NO_TASK   = 2'b11;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_op;
    logic       r_owner;
    logic [3:0] r_burst;
    logic [7:0] r_wait_cnt;
    logic       r_cpu_done;
    logic       r_snp_done;
    logic       r_timeout;

    logic w_cpu_elig;
    logic w_snp_elig;
    logic w_grant_ok;
    logic w_cpu_win;
    logic w_snp_win;
    logic w_complete;
    logic w_expire;

    // The reset term keeps the accepts low while reset is held, even though
    // the state register already reads IDLE.
    assign w_cpu_elig = cpu_valid && !cpu_op[1];
    assign w_snp_elig = snp_valid && (snp_op != NO_TASK);
    assign w_grant_ok = reset && (r_state == ST_IDLE) && cache_ready;
    assign w_cpu_win  = w_grant_ok && w_cpu_elig && (!w_snp_elig || (r_burst == BURST_MAX));
    assign w_snp_win  = w_grant_ok && w_snp_elig && !(w_cpu_elig && (r_burst == BURST_MAX));

    // A completion in the last allowed wait cycle wins over the timeout.
    assign w_complete = (r_state == ST_WAIT) && cache_complete;
    assign w_expire   = (r_state == ST_WAIT) && !cache_complete && (r_wait_cnt == WAIT_LAST);

    assign cpu_accept    = w_cpu_win;
    assign snp_accept    = w_snp_win;
    assign busy          = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign owner         = r_owner && busy;
    assign cache_request = (r_state == ST_ISSUE) ? r_op : NO_TASK;
    assign cpu_done      = r_cpu_done;
    assign snp_done      = r_snp_done;
    assign timeout_err   = r_timeout;
    assign o_dbg_state   = r_state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant -> one issue cycle -> wait for completion or timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cpu_win || w_snp_win) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_complete || w_expire) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the granted op and its owner at the grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= NO_TASK;
            r_owner <= 1'b0;
        end else if (w_cpu_win || w_snp_win) begin
            r_op    <= w_snp_win ? snp_op : cpu_op;
            r_owner <= w_snp_win;
        end
    end

    // Count consecutive snoop grants made while the CPU waits; any IDLE cycle without
    // an eligible CPU request, or a CPU grant, restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_burst <= 4'd0;
        end else if (r_state == ST_IDLE) begin
            if (!w_cpu_elig || w_cpu_win) begin
                r_burst <= 4'd0;
            end else if (w_snp_win && (r_burst != BURST_MAX)) begin
                r_burst <= 4'(r_burst + 4'd1);
            end
        end
    end

    // Count cycles in WAIT_DONE, starting at 0 on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= 8'(r_wait_cnt + 8'd1);
        end
    end

    // Registered result pulses, visible in the cycle the FSM is back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_done <= 1'b0;
            r_snp_done <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_cpu_done <= w_complete && !r_owner;
            r_snp_done <= w_complete && r_owner;
            r_timeout  <= w_expire;
        end
    end

endmodule

// File: doc/cache_access_arbiter.md
CACHE_ACCESS_ARBITER -- requirements
Module: cache_access_arbiter

Interface
REQ-001 SHALL have parameter MAX_SNP_BURST, 4, max consecutive snoop grants while a CPU request waits (range 1-15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 64, max WAIT_DONE cycles before abort (range 2-255).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_valid  input  1  CPU request pending.
REQ-006 SHALL have port cpu_op  input  2  CPU op: 00 read, 01 write; 10/11 not arbitrated.
REQ-007 SHALL have port cpu_accept  output  1  one-cycle pulse, CPU request taken.
REQ-008 SHALL have port snp_valid  input  1  interconnect snoop request pending.
REQ-009 SHALL have port snp_op  input  2  snoop op, forwarded unchanged; 11 not arbitrated.
REQ-010 SHALL have port snp_accept  output  1  one-cycle pulse, snoop request taken.
REQ-011 SHALL have port cache_request  output  2  op to cache controller; 2'b11 = no task.
REQ-012 SHALL have port cache_ready  input  1  cache controller idle.
REQ-013 SHALL have port cache_complete  input  1  cache controller finished current op.
REQ-014 SHALL have port cpu_done  output  1  one-cycle pulse, CPU op completed.
REQ-015 SHALL have port snp_done  output  1  one-cycle pulse, snoop op completed.
REQ-016 SHALL have port owner  output  1  0 = CPU, 1 = snoop; valid while busy.
REQ-017 SHALL have port busy  output  1  high in ISSUE and WAIT_DONE.
REQ-018 SHALL have port timeout_err  output  1  one-cycle pulse on abort.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_DONE.
REQ-020 IDLE: when cache_ready=1 and an eligible request exists (cpu_valid with cpu_op in {00,01}, or snp_valid with snp_op!=11), SHALL select a winner, pulse its accept, register op and owner, go to ISSUE next cycle.
REQ-021 Arbitration SHALL favour snoop, except CPU wins when cpu eligible and snoop burst counter == MAX_SNP_BURST.
REQ-022 Burst counter SHALL increment on each snoop grant while CPU is eligible, saturating at MAX_SNP_BURST; clear on CPU grant and on any IDLE cycle with CPU not eligible.
REQ-023 ISSUE: cache_request SHALL equal the registered op for exactly one cycle; then go to WAIT_DONE.
REQ-024 cache_request SHALL be 2'b11 in every state except ISSUE.
REQ-025 WAIT_DONE: on cache_complete=1, SHALL pulse cpu_done or snp_done per owner next cycle... concretely: done pulse registered, asserted in the cycle after cache_complete is sampled, and state returns to IDLE in that same cycle.
REQ-026 cache_complete SHALL be ignored outside WAIT_DONE.
REQ-027 WAIT_DONE cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES without cache_complete, SHALL pulse timeout_err, produce no done pulse, return to IDLE.
REQ-028 cache_complete and timeout in the same cycle SHALL resolve as completion (done pulse, no timeout_err).
REQ-029 No new accept SHALL occur while busy=1; accept pulses SHALL only occur in IDLE.
REQ-030 Minimum accept-to-accept spacing SHALL be 4 cycles (accept, ISSUE, WAIT_DONE >=1, done/IDLE).

Reset
REQ-031 While reset=0: state IDLE, cache_request=2'b11, cpu_accept, snp_accept, cpu_done, snp_done, timeout_err, busy, owner all 0; burst and timeout counters 0.
REQ-032 Reset asserted mid-operation SHALL drop the in-flight op with no done or timeout pulse.

Verification
REQ-033 CPU read only, cache_complete 2 cycles after ISSUE -> cpu_accept at T0, cache_request=00 at T1 only, cpu_done at T4, busy T1-T3.
REQ-034 cpu_valid and snp_valid held continuously, MAX_SNP_BURST=4, immediate completion -> grant sequence S,S,S,S,C,S,S,S,S,C.
REQ-035 cpu_op=11 with cpu_valid=1, snp_valid=0 -> no accept, cache_request stays 11, busy stays 0.
REQ-036 cache_complete never asserted, TIMEOUT_CYCLES=64 -> timeout_err single pulse after 64 WAIT_DONE cycles, no done pulse, busy falls.
REQ-037 reset driven 0 in WAIT_DONE -> all outputs at reset values asynchronously; after release, fresh snoop request accepted normally.
REQ-038 cache_ready=0 with both requests pending -> no accept until cache_ready=1, then snoop wins.
